// File: rtl/pmt_master_arb_if.sv
// Bundle of the shared PMT master write stream: per-requester beat inputs,
// the forwarded word and the arbiter status outputs.
interface pmt_master_arb_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ*32-1:0] req_data_i;
    logic [NUM_REQ-1:0]    req_vld_i;
    logic [NUM_REQ-1:0]    req_last_i;
    logic [NUM_REQ-1:0]    req_rdy_o;
    logic                  pmt_busy_i;
    logic [31:0]           master_wr_data_o;
    logic                  master_wr_vld_o;
    logic [NUM_REQ-1:0]    grant_o;
    logic                  timeout_err_o;
    logic                  arb_busy_o;

    // Arbiter side
    modport master (
        input  req_data_i, req_vld_i, req_last_i, pmt_busy_i,
        output req_rdy_o, master_wr_data_o, master_wr_vld_o,
        grant_o, timeout_err_o, arb_busy_o
    );

    // Requester / downstream side
    modport slave (
        output req_data_i, req_vld_i, req_last_i, pmt_busy_i,
        input  req_rdy_o, master_wr_data_o, master_wr_vld_o,
        grant_o, timeout_err_o, arb_busy_o
    );
endinterface

// File: rtl/pmt_master_arb.sv
// Packet-atomic round-robin arbiter for the PMT master write stream, with a
// fixed idle gap after each packet and a stall timeout that aborts the owner.
module pmt_master_arb #(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 32768
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    pmt_master_arb_if.master  bus
);
    localparam int DATA_W = 32;
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      GAP_LIMIT = 8'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t              state;
    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    own_idx;
    logic [TO_W-1:0]     to_cnt;
    logic [7:0]          gap_cnt;
    logic                to_err;
    logic                busy;
    logic [DATA_W-1:0]   wr_data_p1;
    logic                wr_vld_p1;

    logic [NUM_REQ-1:0]  rdy_p0;
    logic                vld_p0;
    logic                last_p0;
    logic [DATA_W-1:0]   data_p0;
    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W-1:0]    cand;
    logic [PTR_W-1:0]    next_ptr;

    function automatic logic [TO_W-1:0] to_inc(input logic [TO_W-1:0] v);
        to_inc = (v == {TO_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] gap_inc(input logic [7:0] v);
        gap_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Stage p0: owner beat acceptance, combinational from the registered grant
    assign rdy_p0  = (state == XFER) ? grant : '0;
    assign vld_p0  = |(bus.req_vld_i & rdy_p0);
    assign last_p0 = |(bus.req_last_i & bus.req_vld_i & rdy_p0);
    assign data_p0 = bus.req_data_i[own_idx*DATA_W +: DATA_W];

    // First valid requester at or above the RR pointer, wrapping around
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!win_found && bus.req_vld_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            own_idx    <= '0;
            to_cnt     <= '0;
            gap_cnt    <= '0;
            to_err     <= 1'b0;
            busy       <= 1'b0;
            wr_data_p1 <= '0;
            wr_vld_p1  <= 1'b0;
        end else begin
            wr_vld_p1 <= 1'b0;
            to_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.pmt_busy_i && win_found) begin
                        grant   <= NUM_REQ'(1) << win_idx;
                        own_idx <= win_idx;
                        rr_ptr  <= next_ptr;
                        to_cnt  <= '0;
                        busy    <= 1'b1;
                        state   <= XFER;
                    end
                end
                XFER: begin
                    // Stage p1: registered forwarding of the accepted beat
                    if (vld_p0) begin
                        wr_vld_p1  <= 1'b1;
                        wr_data_p1 <= data_p0;
                        to_cnt     <= '0;
                        if (last_p0) begin
                            grant   <= '0;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end else if (to_cnt >= TO_LIMIT) begin
                        grant   <= '0;
                        gap_cnt <= '0;
                        to_err  <= 1'b1;
                        state   <= GAP;
                    end else begin
                        to_cnt <= to_inc(to_cnt);
                    end
                end
                GAP: begin
                    if (gap_cnt >= GAP_LIMIT) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_inc(gap_cnt);
                    end
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_rdy_o        = rdy_p0;
    assign bus.master_wr_data_o = wr_data_p1;
    assign bus.master_wr_vld_o  = wr_vld_p1;
    assign bus.grant_o          = grant;
    assign bus.timeout_err_o    = to_err;
    assign bus.arb_busy_o       = busy;
endmodule

// File: tb/tb_pmt_master_arb.sv
// Directed bench for pmt_master_arb with two requesters, a 4-cycle gap and an
// 8-cycle stall timeout.
module tb_pmt_master_arb;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    pmt_master_arb_if #(.NUM_REQ(2)) bus ();

    pmt_master_arb #(
        .NUM_REQ       (2),
        .GAP_CYCLES    (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l,
                         input logic [31:0] d0, input logic [31:0] d1);
        bus.req_vld_i  = v;
        bus.req_last_i = l;
        bus.req_data_i = {d1, d0};
    endtask

    int          c [2];
    int          cyc;
    int          q_cyc [$];
    logic [31:0] q_dat [$];
    logic [1:0]  q_gnt [$];
    logic [1:0]  rdy_prev, vld_prev, prev_g, v, l;
    logic [31:0] exp_d [8];
    int          exp_sp [7];
    logic [1:0]  exp_g [4];

    initial begin
        exp_d  = '{32'h0A00, 32'h0A01, 32'h0B00, 32'h0B01,
                   32'h0A02, 32'h0A03, 32'h0B02, 32'h0B03};
        exp_sp = '{1, 7, 1, 7, 1, 7, 1};
        exp_g  = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst_n = 1'b0;
        bus.pmt_busy_i = 1'b0;
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        tick(); tick();
        chk("rst_grant", bus.grant_o, 0);
        chk("rst_vld", bus.master_wr_vld_o, 0);
        chk("rst_data", bus.master_wr_data_o, 0);
        chk("rst_busy", bus.arb_busy_o, 0);
        chk("rst_to", bus.timeout_err_o, 0);
        chk("rst_rdy", bus.req_rdy_o, 0);
        rst_n = 1'b1;
        tick();

        // Single requester, 4-beat packet
        drive(2'b01, 2'b00, 32'h0000_0100, 32'h0);
        tick();
        chk("t1_grant", bus.grant_o, 2'b01);
        chk("t1_rdy", bus.req_rdy_o, 2'b01);
        chk("t1_busy", bus.arb_busy_o, 1);
        chk("t1_novld", bus.master_wr_vld_o, 0);
        tick();
        chk("t1_b0_vld", bus.master_wr_vld_o, 1);
        chk("t1_b0_dat", bus.master_wr_data_o, 32'h100);
        drive(2'b01, 2'b00, 32'h11, 32'h0);
        tick();
        chk("t1_b1_vld", bus.master_wr_vld_o, 1);
        chk("t1_b1_dat", bus.master_wr_data_o, 32'h11);
        drive(2'b01, 2'b00, 32'h22, 32'h0);
        tick();
        chk("t1_b2_dat", bus.master_wr_data_o, 32'h22);
        drive(2'b01, 2'b01, 32'h33, 32'h0);
        tick();
        chk("t1_b3_vld", bus.master_wr_vld_o, 1);
        chk("t1_b3_dat", bus.master_wr_data_o, 32'h33);
        chk("t1_gap_grant", bus.grant_o, 0);
        chk("t1_gap_rdy", bus.req_rdy_o, 0);
        chk("t1_gap_busy", bus.arb_busy_o, 1);
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        tick();
        chk("t1_post_vld", bus.master_wr_vld_o, 0);
        chk("t1_hold_dat", bus.master_wr_data_o, 32'h33);
        chk("t1_gap_busy1", bus.arb_busy_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_gap_busyn", bus.arb_busy_o, 1);
        end
        tick();
        chk("t1_idle_busy", bus.arb_busy_o, 0);

        // Parser busy blocks the grant; single-beat packet from requester 1
        bus.pmt_busy_i = 1'b1;
        drive(2'b10, 2'b10, 32'h0, 32'hA5A5_0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_blocked", bus.grant_o, 0);
        end
        bus.pmt_busy_i = 1'b0;
        tick();
        chk("t3_grant", bus.grant_o, 2'b10);
        chk("t3_rdy", bus.req_rdy_o, 2'b10);
        tick();
        chk("t3_vld", bus.master_wr_vld_o, 1);
        chk("t3_dat", bus.master_wr_data_o, 32'hA5A5_0001);
        chk("t3_gap_grant", bus.grant_o, 0);
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        tick();
        chk("t3_one_strobe", bus.master_wr_vld_o, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("t3_idle", bus.arb_busy_o, 0);

        // Both requesters streaming 2-beat packets
        c[0] = 0; c[1] = 0; cyc = 0; prev_g = 2'b00;
        drive(2'b11, 2'b00, 32'h0A00, 32'h0B00);
        for (int i = 0; i < 200 && q_dat.size() < 8; i++) begin
            rdy_prev = bus.req_rdy_o;
            vld_prev = bus.req_vld_i;
            tick();
            cyc++;
            for (int k = 0; k < 2; k++)
                if (rdy_prev[k] && vld_prev[k]) c[k]++;
            for (int k = 0; k < 2; k++) begin
                v[k] = (c[k] < 4);
                l[k] = (c[k] % 2 == 1);
            end
            drive(v, l, 32'h0A00 + c[0], 32'h0B00 + c[1]);
            if (bus.master_wr_vld_o) begin
                q_dat.push_back(bus.master_wr_data_o);
                q_cyc.push_back(cyc);
            end
            if (bus.grant_o != 2'b00 && prev_g == 2'b00) q_gnt.push_back(bus.grant_o);
            prev_g = bus.grant_o;
        end
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        chk("t2_nstrobes", q_dat.size(), 8);
        chk("t2_ngrants", q_gnt.size(), 4);
        for (int i = 0; i < 8; i++)
            if (i < q_dat.size()) chk("t2_data", q_dat[i], exp_d[i]);
        for (int i = 0; i < 7; i++)
            if (i + 1 < q_cyc.size()) chk("t2_spacing", q_cyc[i+1] - q_cyc[i], exp_sp[i]);
        for (int i = 0; i < 4; i++)
            if (i < q_gnt.size()) chk("t2_grant_seq", q_gnt[i], exp_g[i]);
        for (int i = 0; i < 5; i++) tick();
        chk("t2_idle", bus.arb_busy_o, 0);

        // Owner stalls mid-packet and is aborted by the timeout
        drive(2'b11, 2'b10, 32'h0C00, 32'h0D00);
        tick();
        chk("t4_grant", bus.grant_o, 2'b01);
        tick();
        chk("t4_b0_dat", bus.master_wr_data_o, 32'h0C00);
        drive(2'b10, 2'b10, 32'h0C01, 32'h0D00);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t4_no_to", bus.timeout_err_o, 0);
            chk("t4_hold_grant", bus.grant_o, 2'b01);
            chk("t4_no_vld", bus.master_wr_vld_o, 0);
        end
        tick();
        chk("t4_to_pulse", bus.timeout_err_o, 1);
        chk("t4_to_grant", bus.grant_o, 0);
        chk("t4_to_busy", bus.arb_busy_o, 1);
        chk("t4_to_novld", bus.master_wr_vld_o, 0);
        drive(2'b11, 2'b10, 32'h0C01, 32'h0D00);
        tick();
        chk("t4_to_single", bus.timeout_err_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_gap_grant", bus.grant_o, 0);
        end
        tick();
        chk("t4_next_grant", bus.grant_o, 2'b10);
        tick();
        chk("t4_d_vld", bus.master_wr_vld_o, 1);
        chk("t4_d_dat", bus.master_wr_data_o, 32'h0D00);
        drive(2'b01, 2'b00, 32'h0C01, 32'h0);

        // Reset while requester 0 is streaming
        for (int i = 0; i < 20 && bus.grant_o != 2'b01; i++) tick();
        chk("t5_grant_wait", bus.grant_o, 2'b01);
        tick();
        chk("t5_stream_vld", bus.master_wr_vld_o, 1);
        chk("t5_stream_dat", bus.master_wr_data_o, 32'h0C01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_vld", bus.master_wr_vld_o, 0);
        chk("t5_async_grant", bus.grant_o, 0);
        chk("t5_async_rdy", bus.req_rdy_o, 0);
        chk("t5_async_busy", bus.arb_busy_o, 0);
        chk("t5_async_to", bus.timeout_err_o, 0);
        chk("t5_async_dat", bus.master_wr_data_o, 0);
        tick();
        drive(2'b11, 2'b00, 32'h0E00, 32'h0F00);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_rr_reset", bus.grant_o, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pmt_master_arb.md
Name: pmt_master_arb

Overview:
- Shares the single 32-bit PMT master write stream, which feeds the PMT master selector and command parser, between NUM_REQ independent command sources (host register path, local scan sequencer, ...).
- Grants are packet-atomic and round-robin.
- Each granted packet is followed by a guaranteed idle gap, so the parser can close one command before the next header arrives.
- A stalled requester is aborted by a timeout so that it cannot lock the stream.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
GAP_CYCLES, 16, idle cycles inserted after every packet end/abort (0..255)
TIMEOUT_CYCLES, 32768, max consecutive cycles in XFER without an accepted beat before abort (>=2)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
req_data_i  in  NUM_REQ*32  per-requester data word, requester k at bits [32k+31:32k]
req_vld_i  in  NUM_REQ  per-requester beat valid
req_last_i  in  NUM_REQ  per-requester last beat of packet (qualified by vld)
req_rdy_o  out  NUM_REQ  per-requester beat accept
pmt_busy_i  in  1  downstream parser busy; blocks new grants
master_wr_data_o  out  32  forwarded word
master_wr_vld_o  out  1  forwarded word strobe (no back-pressure downstream)
grant_o  out  NUM_REQ  one-hot current owner, 0 when none
timeout_err_o  out  1  one-cycle pulse on abort
arb_busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert by clk_i): state=IDLE, all outputs 0, RR pointer=0 (requester 0 has highest priority), counters=0.
- States: IDLE, XFER, GAP.
- IDLE:
  - If pmt_busy_i=0 and |req_vld_i, select the first requester with vld set, scanning upward (with wrap) from the RR pointer.
  - Register it into grant_o, set RR pointer = winner+1 mod NUM_REQ, go to XFER next cycle.
  - If pmt_busy_i=1, no grant regardless of requests.
- XFER:
  - req_rdy_o[k] = (state==XFER) & grant_o[k], combinational; all other rdy bits are 0.
  - Beat accepted when vld&rdy of the owner.
  - Accepted beat appears on master_wr_data_o with master_wr_vld_o=1 exactly 1 cycle later (registered). master_wr_vld_o=0 on all other cycles. master_wr_data_o holds its last value when not valid.
  - An accepted beat with req_last_i=1 -> GAP next cycle, grant_o cleared.
  - Timeout counter clears on every accepted beat and increments on every XFER cycle without one. When the count reaches TIMEOUT_CYCLES: go to GAP, clear grant_o, pulse timeout_err_o for 1 cycle. No further beats from that requester are forwarded.
  - pmt_busy_i is ignored in XFER.
- GAP:
  - Lasts exactly GAP_CYCLES+1 cycles, then IDLE. Minimum spacing between the last forwarded strobe and the next packet's first strobe is GAP_CYCLES+3 cycles.
  - req_rdy_o all 0.
- A single-beat packet (vld and last together on the first accepted beat) is legal.
- Requests deasserting in IDLE before a grant: no grant is issued, RR pointer unchanged.
- Reset mid-XFER: forwarding stops immediately, master_wr_vld_o=0, no timeout pulse.
- Counters saturate and never wrap. Timeout counter width is clog2(TIMEOUT_CYCLES+1); gap counter is 8 bits.
- The block does not inspect packet contents.

Test Plan:
- Single requester, 4-beat packet 0x0000_0100,0x11,0x22,0x33(last), GAP_CYCLES=4 -> four vld strobes, each one cycle after its accept, data in order. arb_busy_o high through XFER plus 5 GAP cycles, then IDLE.
- Both requesters vld continuously, 2-beat packets -> grants alternate 0,1,0,1. No beat interleaving. Gap of GAP_CYCLES+3 between packets.
- pmt_busy_i=1 while req 1 valid -> no grant. pmt_busy_i falls -> grant_o=2'b10 the next cycle.
- Owner drops vld mid-packet with TIMEOUT_CYCLES=8 -> timeout_err_o pulses after 8 idle XFER cycles, then GAP. Next grant goes to the other pending requester.
- Assert rst_n_i low mid-XFER -> outputs 0 asynchronously. After release, with both requesters valid, requester 0 wins first.
- Single-beat packet with last on the first beat -> exactly one strobe, then GAP.
